// File: rtl/flag_register_unit.sv
// NZCV flag register and B.cond evaluator; the decision is registered one cycle after accept, and stall holds all state.
// Hazard backpressure asks upstream to hold the branch. With FLAG_FORWARD_EN, EX flags bypass to the evaluator and hazard is 0.
module flag_register_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         NV_ALWAYS   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       ex_set_flags,
  input  logic       ex_neg,
  input  logic       ex_zero,
  input  logic       ex_carry,
  input  logic       ex_overflow,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  input  logic       stall,
  input  logic       flush,
  output logic [3:0] nzcv,
  output logic       hazard,
  output logic       take_valid,
  output logic       take
);

  logic [3:0] ex_flags;
  logic [3:0] eff;
  logic       ex_producing;
  logic       flag_wr;
  logic       br_accept;
  logic       cond_true;

  assign ex_flags     = {ex_neg, ex_zero, ex_carry, ex_overflow};
  assign ex_producing = ex_valid & ex_set_flags & !flush;
  assign flag_wr      = ex_producing & !stall;

`ifdef FLAG_FORWARD_EN
  assign eff    = ex_producing ? ex_flags : nzcv;
  assign hazard = 1'b0;
`else
  assign eff    = nzcv;
  assign hazard = br_valid & ex_producing;
`endif

  assign br_accept = br_valid & !stall & !flush & !hazard;

  // Even codes test the base predicate; odd codes invert it, except for the 111x pair.
  always_comb begin
    logic base;
    base      = 1'b0;
    cond_true = 1'b0;
    case (br_cond[3:1])
      3'd0: base = eff[2];
      3'd1: base = eff[1];
      3'd2: base = eff[3];
      3'd3: base = eff[0];
      3'd4: base = eff[1] & !eff[2];
      3'd5: base = (eff[3] == eff[0]);
      3'd6: base = !eff[2] & (eff[3] == eff[0]);
      default: base = 1'b1;
    endcase
    if (br_cond[3:1] == 3'd7)
      cond_true = br_cond[0] ? NV_ALWAYS : 1'b1;
    else
      cond_true = base ^ br_cond[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv       <= RESET_FLAGS;
      take_valid <= 1'b0;
      take       <= 1'b0;
    end else if (flush) begin
      take_valid <= 1'b0;
      take       <= 1'b0;
    end else if (!stall) begin
      if (flag_wr)
        nzcv <= ex_flags;
      take_valid <= br_accept;
      take       <= br_accept & cond_true;
    end
  end

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed bench for flag_register_unit. The driver queues expected decisions, and a monitor pops them on each new take_valid pulse.
module tb_flag_register_unit;

  localparam bit NV = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ex_valid = 1'b0, ex_set_flags = 1'b0;
  logic       ex_neg = 1'b0, ex_zero = 1'b0, ex_carry = 1'b0, ex_overflow = 1'b0;
  logic       br_valid = 1'b0;
  logic [3:0] br_cond = 4'd0;
  logic       stall = 1'b0, flush = 1'b0;
  logic [3:0] nzcv;
  logic       hazard, take_valid, take;

  int checks = 0;
  int failures = 0;
  bit exp_q[$];
  bit edge_stall = 1'b0;

  flag_register_unit #(.RESET_FLAGS(4'b0000), .NV_ALWAYS(NV)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .ex_neg(ex_neg), .ex_zero(ex_zero), .ex_carry(ex_carry), .ex_overflow(ex_overflow),
    .br_valid(br_valid), .br_cond(br_cond), .stall(stall), .flush(flush),
    .nzcv(nzcv), .hazard(hazard), .take_valid(take_valid), .take(take)
  );

  always #5 clk = ~clk;

  function automatic bit exp_take(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      4'd14: return 1'b1;
      default: return NV;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_in(input logic ev, input logic sf, input logic [3:0] f,
                        input logic bv, input logic [3:0] c, input logic st, input logic fl);
    ex_valid = ev; ex_set_flags = sf;
    {ex_neg, ex_zero, ex_carry, ex_overflow} = f;
    br_valid = bv; br_cond = c; stall = st; flush = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a new decision appears only after an edge that was not stalled.
  always @(posedge clk) edge_stall = stall;

  always @(negedge clk) begin
    if (take_valid && !edge_stall && !reset) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_decision actual=%0b required=none", take);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (take !== e) begin
          failures++;
          $display("FAIL take actual=%0b required=%0b", take, e);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_nzcv", nzcv, 4'b0000);
    chk("rst_take_valid", take_valid, 0);
    chk("rst_take", take, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // Mid-cycle async reset with nzcv=1111 and a decision in flight.
    set_in(1, 1, 4'b1111, 0, 0, 0, 0); cyc();
    chk("nzcv_1111", nzcv, 4'b1111);
    set_in(0, 0, 0, 1, 4'd14, 0, 0); cyc();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_take_valid", take_valid, 1);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_nzcv", nzcv, 4'b0000);
    chk("async_rst_take_valid", take_valid, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // SUBS result zero, then B.EQ and B.HI.
    set_in(1, 1, 4'b0110, 0, 0, 0, 0); cyc();
    chk("subs_nzcv", nzcv, 4'b0110);
    set_in(0, 0, 0, 1, 4'd0, 0, 0); exp_q.push_back(1'b1); cyc();
    set_in(0, 0, 0, 1, 4'd8, 0, 0); exp_q.push_back(1'b0); cyc();
    set_in(0, 0, 0, 0, 0, 0, 0); cyc();

    // Producer and consumer in the same cycle: N=1, V=0 with B.LT.
    set_in(1, 1, 4'b1000, 1, 4'd11, 0, 0);
    #1;
`ifdef FLAG_FORWARD_EN
    chk("fwd_hazard", hazard, 0);
    exp_q.push_back(1'b1);
    cyc();
`else
    chk("nofwd_hazard", hazard, 1);
    cyc();
    set_in(0, 0, 0, 1, 4'd11, 0, 0);
    #1;
    chk("retry_hazard", hazard, 0);
    exp_q.push_back(1'b1);
    cyc();
`endif
    set_in(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("lt_nzcv", nzcv, 4'b1000);

    // Stall holds decision and flags for three cycles.
    set_in(0, 0, 0, 1, 4'd14, 0, 0); exp_q.push_back(1'b1); cyc();
    set_in(1, 1, 4'b0101, 1, 4'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("stall%0d_take_valid", i), take_valid, 1);
      chk($sformatf("stall%0d_take", i), take, 1);
      chk($sformatf("stall%0d_nzcv", i), nzcv, 4'b1000);
    end
    set_in(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("post_stall_take_valid", take_valid, 0);

    // Flush suppresses the write and accept, with and without stall.
    set_in(1, 1, 4'b0011, 0, 0, 0, 0); cyc();
    set_in(1, 1, 4'b1000, 1, 4'd14, 0, 1); cyc();
    chk("flush_nzcv", nzcv, 4'b0011);
    chk("flush_take_valid", take_valid, 0);
    set_in(0, 0, 0, 1, 4'd14, 0, 0); exp_q.push_back(1'b1); cyc();
    set_in(1, 1, 4'b1000, 1, 4'd14, 1, 1); cyc();
    chk("flush_stall_take_valid", take_valid, 0);
    chk("flush_stall_nzcv", nzcv, 4'b0011);
    set_in(0, 0, 0, 0, 0, 0, 0); cyc();

    // Full sweep: 16 flag values x 16 condition codes, branches back to back.
    for (int v = 0; v < 16; v++) begin
      set_in(1, 1, 4'(v), 0, 0, 0, 0); cyc();
      chk($sformatf("sweep_nzcv_%0d", v), nzcv, 32'(v));
      for (int c = 0; c < 16; c++) begin
        set_in(0, 0, 0, 1, 4'(c), 0, 0);
        exp_q.push_back(exp_take(4'(c), 4'(v)));
        cyc();
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
